// File: rtl/repl_pkg.sv
// Shared types and constants for the 4-way cache replacement controller.
// Holds the FSM state enum, counter/index widths and one-hot helpers.
package repl_pkg;

  localparam int CTR_W = 3;
  localparam int IDX_W = 2;
  localparam int NSETS = 1 << IDX_W;

  localparam logic [CTR_W-1:0] CTR_LOAD_VAL = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    WAIT_FILL,
    UPDATE,
    HIT_UPD
  } state_t;

  function automatic logic [NSETS-1:0] set_1h(
    input logic [IDX_W-1:0] i
  );
    return NSETS'(1) << i;
  endfunction

  function automatic logic [3:0] way_1h(
    input logic [1:0] w
  );
    return 4'b0001 << w;
  endfunction

endpackage

// File: rtl/repl_ctrl_victim_sel.sv
// Combinational victim picker: lowest invalid way first, otherwise the
// way with the smallest counter (ties to lowest way). Ports: way_valid, ctr_vals -> victim.
module victim_sel
  import repl_pkg::*;
(
  input  logic [3:0]         way_valid,
  input  logic [4*CTR_W-1:0] ctr_vals,
  output logic [1:0]         victim
);

  logic             w_found;
  logic [CTR_W-1:0] w_min;

  always_comb begin
    w_found = 1'b0;
    w_min   = ctr_vals[0 +: CTR_W];
    victim  = 2'd0;
    for (int w = 0; w < 4; w++) begin
      if (!way_valid[w] && !w_found) begin
        victim  = 2'(w);
        w_found = 1'b1;
      end
    end
    if (!w_found) begin
      for (int w = 1; w < 4; w++) begin
        // strict compare keeps the lowest way on ties
        if (ctr_vals[w*CTR_W +: CTR_W] < w_min) begin
          w_min  = ctr_vals[w*CTR_W +: CTR_W];
          victim = 2'(w);
        end
      end
    end
  end

endmodule

// File: rtl/repl_ctrl.sv
// Replacement controller: picks a victim on a miss, ages the other ways
// after the fill, refreshes the hit way on a hit. All outputs registered.
module repl_ctrl
  import repl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               miss_req,
  input  logic [IDX_W-1:0]   miss_index,
  input  logic               hit_req,
  input  logic [IDX_W-1:0]   hit_index,
  input  logic [1:0]         hit_way,
  input  logic [3:0]         way_valid,
  input  logic               fill_done,
  input  logic [4*CTR_W-1:0] ctr_vals,
  output logic [IDX_W-1:0]   ctr_index,
  output logic [NSETS-1:0]   ctr_index_dec,
  output logic [3:0]         ctr_dec,
  output logic [3:0]         ctr_load,
  output logic [1:0]         victim_way,
  output logic               victim_valid,
  output logic               busy,
  output logic               miss_ack,
  output logic               hit_ack
);

  state_t             r_state, w_state;
  logic [IDX_W-1:0]   r_idx, w_idx;
  logic [NSETS-1:0]   r_idx_dec, w_idx_dec;
  logic [3:0]         r_dec, w_dec;
  logic [3:0]         r_load, w_load;
  logic [1:0]         r_vic, w_vic;
  logic               r_vv, w_vv;
  logic               r_busy, w_busy;
  logic               r_mack, w_mack;
  logic               r_hack, w_hack;
  logic [4*CTR_W-1:0] r_snap, w_snap;
  logic [1:0]         w_pick;

  victim_sel u_vsel (
    .way_valid (way_valid),
    .ctr_vals  (ctr_vals),
    .victim    (w_pick)
  );

  always_comb begin
    w_state   = r_state;
    w_idx     = r_idx;
    w_idx_dec = r_idx_dec;
    w_dec     = 4'd0;
    w_load    = 4'd0;
    w_vic     = r_vic;
    w_vv      = r_vv;
    w_busy    = r_busy;
    w_mack    = 1'b0;
    w_hack    = 1'b0;
    w_snap    = r_snap;
    unique case (r_state)
      IDLE: begin
        if (miss_req) begin
          w_idx     = miss_index;
          w_idx_dec = set_1h(miss_index);
          w_busy    = 1'b1;
          w_state   = SAMPLE;
        end else if (hit_req) begin
          w_idx     = hit_index;
          w_idx_dec = set_1h(hit_index);
          w_busy    = 1'b1;
          w_load    = way_1h(hit_way);
          w_hack    = 1'b1;
          w_state   = HIT_UPD;
        end
      end
      SAMPLE: begin
        w_vic   = w_pick;
        w_vv    = 1'b1;
        // keep the sampled counters: the decrement mask is built later
        w_snap  = ctr_vals;
        w_state = WAIT_FILL;
      end
      WAIT_FILL: begin
        if (fill_done) begin
          w_load = way_1h(r_vic);
          for (int w = 0; w < 4; w++) begin
            // a counter already at zero is left alone (no wrap)
            w_dec[w] = (2'(w) != r_vic) &&
                       (r_snap[w*CTR_W +: CTR_W] != '0);
          end
          w_mack  = 1'b1;
          w_vv    = 1'b0;
          w_state = UPDATE;
        end
      end
      UPDATE, HIT_UPD: begin
        w_idx_dec = '0;
        w_busy    = 1'b0;
        w_state   = IDLE;
      end
      default: begin
        w_idx_dec = '0;
        w_busy    = 1'b0;
        w_vv      = 1'b0;
        w_state   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_idx_dec <= '0;
      r_dec     <= '0;
      r_load    <= '0;
      r_vic     <= '0;
      r_vv      <= 1'b0;
      r_busy    <= 1'b0;
      r_mack    <= 1'b0;
      r_hack    <= 1'b0;
      r_snap    <= '0;
    end else begin
      r_state   <= w_state;
      r_idx     <= w_idx;
      r_idx_dec <= w_idx_dec;
      r_dec     <= w_dec;
      r_load    <= w_load;
      r_vic     <= w_vic;
      r_vv      <= w_vv;
      r_busy    <= w_busy;
      r_mack    <= w_mack;
      r_hack    <= w_hack;
      r_snap    <= w_snap;
    end
  end

  assign ctr_index     = r_idx;
  assign ctr_index_dec = r_idx_dec;
  assign ctr_dec       = r_dec;
  assign ctr_load      = r_load;
  assign victim_way    = r_vic;
  assign victim_valid  = r_vv;
  assign busy          = r_busy;
  assign miss_ack      = r_mack;
  assign hit_ack       = r_hack;

endmodule

// File: tb/tb_repl_ctrl.sv
// Self-checking bench for repl_ctrl: directed cases plus randomized
// miss/hit traffic checked against a key-ordering victim model.
module tb_repl_ctrl;
  import repl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        miss_req = 1'b0;
  logic [1:0]  miss_index = '0;
  logic        hit_req = 1'b0;
  logic [1:0]  hit_index = '0;
  logic [1:0]  hit_way = '0;
  logic [3:0]  way_valid = 4'hF;
  logic        fill_done = 1'b0;
  logic [11:0] ctr_vals = '0;
  logic [1:0]  ctr_index;
  logic [3:0]  ctr_index_dec;
  logic [3:0]  ctr_dec;
  logic [3:0]  ctr_load;
  logic [1:0]  victim_way;
  logic        victim_valid;
  logic        busy;
  logic        miss_ack;
  logic        hit_ack;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  repl_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .miss_req      (miss_req),
    .miss_index    (miss_index),
    .hit_req       (hit_req),
    .hit_index     (hit_index),
    .hit_way       (hit_way),
    .way_valid     (way_valid),
    .fill_done     (fill_done),
    .ctr_vals      (ctr_vals),
    .ctr_index     (ctr_index),
    .ctr_index_dec (ctr_index_dec),
    .ctr_dec       (ctr_dec),
    .ctr_load      (ctr_load),
    .victim_way    (victim_way),
    .victim_valid  (victim_valid),
    .busy          (busy),
    .miss_ack      (miss_ack),
    .hit_ack       (hit_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Victim = way with the smallest key; invalid ways rank below any
  // valid one, valid ways rank by counter then way number.
  function automatic logic [1:0] ref_victim(input logic [3:0] vld,
                                            input logic [11:0] v);
    int best = 1 << 20;
    int key;
    for (int w = 0; w < 4; w++) begin
      key = vld[w] ? ((8 + int'(v[w*3 +: 3])) * 4 + w) : w;
      if (key < best) best = key;
    end
    return 2'(best % 4);
  endfunction

  function automatic logic [3:0] ref_dec(input logic [11:0] v,
                                         input logic [1:0] vic);
    logic [3:0] m = '0;
    for (int w = 0; w < 4; w++)
      if (w != int'(vic) && v[w*3 +: 3] > 0) m[w] = 1'b1;
    return m;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_idec"}, ctr_index_dec, 0);
    chk({tag, "_load"}, ctr_load, 0);
    chk({tag, "_dec"}, ctr_dec, 0);
    chk({tag, "_mack"}, miss_ack, 0);
    chk({tag, "_hack"}, hit_ack, 0);
    chk({tag, "_vv"}, victim_valid, 0);
  endtask

  task automatic do_miss(input logic [1:0] idx, input logic [3:0] vld,
                         input logic [11:0] vals, input bit hit_with,
                         input bit hit_during, input int wait_n);
    logic [1:0] ev;
    logic [3:0] ed;
    ev = ref_victim(vld, vals);
    ed = ref_dec(vals, ev);
    @(negedge clk);
    miss_req   = 1'b1;
    miss_index = idx;
    way_valid  = vld;
    ctr_vals   = vals;
    hit_req    = hit_with;
    hit_index  = 2'($urandom);
    hit_way    = 2'($urandom);
    @(negedge clk);
    hit_req = 1'b0;
    chk("s_busy", busy, 1);
    chk("s_idx", ctr_index, idx);
    chk("s_idec", ctr_index_dec, 4'b0001 << idx);
    chk("s_vv", victim_valid, 0);
    chk("s_hack", hit_ack, 0);
    chk("s_load", ctr_load, 0);
    @(negedge clk);
    chk("w_vv", victim_valid, 1);
    chk("w_vic", victim_way, ev);
    chk("w_load", ctr_load, 0);
    chk("w_dec", ctr_dec, 0);
    // counters on the bus may move now; decisions use the sampled set
    ctr_vals  = 12'($urandom);
    way_valid = 4'($urandom);
    for (int k = 0; k < wait_n; k++) begin
      hit_req   = hit_during;
      hit_index = 2'($urandom);
      hit_way   = 2'($urandom);
      @(negedge clk);
      hit_req = 1'b0;
      chk("wf_hack", hit_ack, 0);
      chk("wf_vv", victim_valid, 1);
      chk("wf_load", ctr_load, 0);
      chk("wf_mack", miss_ack, 0);
    end
    fill_done = 1'b1;
    @(negedge clk);
    fill_done = 1'b0;
    miss_req  = 1'b0;
    chk("u_load", ctr_load, 4'b0001 << ev);
    chk("u_dec", ctr_dec, ed);
    chk("u_mack", miss_ack, 1);
    chk("u_vv", victim_valid, 0);
    chk("u_busy", busy, 1);
    chk("u_idec", ctr_index_dec, 4'b0001 << idx);
    @(negedge clk);
    chk_idle("i");
  endtask

  task automatic do_hit(input logic [1:0] idx, input logic [1:0] way);
    @(negedge clk);
    hit_req   = 1'b1;
    hit_index = idx;
    hit_way   = way;
    @(negedge clk);
    hit_req = 1'b0;
    chk("h_load", ctr_load, 4'b0001 << way);
    chk("h_dec", ctr_dec, 0);
    chk("h_idec", ctr_index_dec, 4'b0001 << idx);
    chk("h_idx", ctr_index, idx);
    chk("h_hack", hit_ack, 1);
    chk("h_busy", busy, 1);
    @(negedge clk);
    chk_idle("hi");
  endtask

  initial begin
    #1;
    chk_idle("rst");
    chk("rst_idx", ctr_index, 0);
    chk("rst_vic", victim_way, 0);
    @(negedge clk);
    reset = 1'b1;

    // reset abandons a miss parked in WAIT_FILL
    @(negedge clk);
    miss_req   = 1'b1;
    miss_index = 2'd2;
    ctr_vals   = 12'o7531;
    way_valid  = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("ra_vv", victim_valid, 1);
    #2;
    reset    = 1'b0;
    miss_req = 1'b0;
    #1;
    chk_idle("ra");
    chk("ra_idx", ctr_index, 0);
    chk("ra_vic", victim_way, 0);
    @(negedge clk);
    reset     = 1'b1;
    fill_done = 1'b1;
    @(negedge clk);
    fill_done = 1'b0;
    chk_idle("rf");
    @(negedge clk);
    chk_idle("rf2");

    do_miss(2'd1, 4'b1011, {3'd7, 3'd0, 3'd5, 3'd3}, 0, 0, 1);
    do_miss(2'd0, 4'b1111, {3'd2, 3'd1, 3'd1, 3'd6}, 0, 0, 2);
    do_miss(2'd3, 4'b1101, {3'd4, 3'd3, 3'd5, 3'd0}, 0, 0, 0);
    do_miss(2'd2, 4'b1111, {3'd0, 3'd0, 3'd0, 3'd0}, 1, 1, 3);
    do_hit(2'd3, 2'd2);
    do_hit(2'd0, 2'd0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0)
        do_hit(2'($urandom), 2'($urandom));
      else
        do_miss(2'($urandom),
                ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom),
                12'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
